// File: rtl/grid_vga_renderer.sv
// 640x480@60 VGA renderer for the 16x16 playfield bus; snapshots grid_in once per frame in vblank.
// Optional build macro GRID_LINES_EN overlays cell gridlines in LINE_COLOR.
module grid_vga_renderer #(
  parameter int          CELL_PX     = 24,
  parameter int          X_OFF       = 128,
  parameter int          Y_OFF       = 48,
  parameter logic [11:0] FILL_COLOR  = 12'hF80,
  parameter logic [11:0] EMPTY_COLOR = 12'h112,
  parameter logic [11:0] BG_COLOR    = 12'h444,
  parameter logic [11:0] LINE_COLOR  = 12'h888,
  parameter int          H_VISIBLE   = 640,
  parameter int          H_FRONT     = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BACK      = 48,
  parameter int          V_VISIBLE   = 480,
  parameter int          V_FRONT     = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BACK      = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] grid_in,
  output logic         hSync,
  output logic         vSync,
  output logic [3:0]   VGA_R,
  output logic [3:0]   VGA_G,
  output logic [3:0]   VGA_B,
  output logic         frame_start,
  output logic         active
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [HW-1:0] X_BEG       = HW'(X_OFF);
  localparam logic [HW-1:0] X_LAST      = HW'(X_OFF + 16 * CELL_PX - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [VW-1:0] Y_BEG       = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_LAST      = VW'(Y_OFF + 16 * CELL_PX - 1);
  localparam logic [SW-1:0] SUB_LAST    = SW'(CELL_PX - 1);

  if ((X_OFF + 16 * CELL_PX > H_VISIBLE) || (Y_OFF + 16 * CELL_PX > V_VISIBLE)) begin : g_fit_fatal
    $fatal(1, "grid_vga_renderer: playfield does not fit inside the visible area");
  end

  logic [1:0]    prescaler_q, prescaler_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [3:0]    col_q, col_d, row_q, row_d;
  logic [255:0]  snap_q, snap_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          active_q, active_d;
  logic          frame_start_q, frame_start_d;

  logic          pix_en, h_wrap, v_wrap, snap_take;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          visible, in_pf, cell_on;
  logic [11:0]   pix_rgb;

  // Sub-cell counters track the *current* (h,v), so they are stepped with the next counter value.
  always_comb begin
    pix_en      = (prescaler_q == 2'd3);
    prescaler_d = prescaler_q + 2'd1;
    h_wrap      = (hcount_q == H_LAST);
    v_wrap      = (vcount_q == V_LAST);
    h_next      = h_wrap ? '0 : hcount_q + HW'(1);
    v_next      = v_wrap ? '0 : vcount_q + VW'(1);

    hcount_d = hcount_q;
    vcount_d = vcount_q;
    sub_x_d  = sub_x_q;
    col_d    = col_q;
    sub_y_d  = sub_y_q;
    row_d    = row_q;

    if (pix_en) begin
      hcount_d = h_next;
      if (h_next == X_BEG) begin
        sub_x_d = '0;
        col_d   = '0;
      end else if (sub_x_q == SUB_LAST) begin
        sub_x_d = '0;
        col_d   = col_q + 4'd1;
      end else begin
        sub_x_d = sub_x_q + SW'(1);
      end

      if (h_wrap) begin
        vcount_d = v_next;
        if (v_next == Y_BEG) begin
          sub_y_d = '0;
          row_d   = '0;
        end else if (sub_y_q == SUB_LAST) begin
          sub_y_d = '0;
          row_d   = row_q + 4'd1;
        end else begin
          sub_y_d = sub_y_q + SW'(1);
        end
      end
    end
  end

  always_comb begin
    visible = (hcount_q < H_VIS_END) && (vcount_q < V_VIS_END);
    in_pf   = (hcount_q >= X_BEG) && (hcount_q <= X_LAST) &&
              (vcount_q >= Y_BEG) && (vcount_q <= Y_LAST);
    cell_on = snap_q[{col_q, row_q}];

    pix_rgb = '0;
    if (visible) begin
      if (in_pf) begin
        pix_rgb = cell_on ? FILL_COLOR : EMPTY_COLOR;
`ifdef GRID_LINES_EN
        if ((sub_x_q == '0) || (sub_y_q == '0) || (hcount_q == X_LAST) || (vcount_q == Y_LAST)) begin
          pix_rgb = LINE_COLOR;
        end
`endif
      end else begin
        pix_rgb = BG_COLOR;
      end
    end
  end

  // Snapshot at the first pixel of vertical blanking so the whole next frame sees one grid.
  always_comb begin
    snap_take     = pix_en && (hcount_q == '0) && (vcount_q == V_VIS_END);
    snap_d        = snap_take ? grid_in : snap_q;
    frame_start_d = snap_take;

    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    rgb_d    = rgb_q;
    active_d = active_q;
    if (pix_en) begin
      hsync_d  = !((hcount_q >= H_SYNC_BEG) && (hcount_q <= H_SYNC_LAST));
      vsync_d  = !((vcount_q >= V_SYNC_BEG) && (vcount_q <= V_SYNC_LAST));
      rgb_d    = pix_rgb;
      active_d = visible;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q   <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      sub_x_q       <= '0;
      col_q         <= '0;
      sub_y_q       <= '0;
      row_q         <= '0;
      snap_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      sub_x_q       <= sub_x_d;
      col_q         <= col_d;
      sub_y_q       <= sub_y_d;
      row_q         <= row_d;
      snap_q        <= snap_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign active      = active_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Directed bench: full-size instance for line timing, shrunken-screen instance for frame/colour behaviour.
`timescale 1ns/1ps
module tb_grid_vga_renderer;

  localparam int CP = 3, XO = 3, YO = 2;
  localparam int HV = 52, HF = 2, HS = 4, HB = 2;
  localparam int VV = 50, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRM = HT * VT;

  localparam logic [11:0] FILL  = 12'hF80;
  localparam logic [11:0] EMPTY = 12'h112;
  localparam logic [11:0] BG    = 12'h444;
  localparam logic [11:0] LINE  = 12'h888;
`ifdef GRID_LINES_EN
  localparam logic [11:0] EDGE_FILL  = LINE;
  localparam logic [11:0] EDGE_EMPTY = LINE;
`else
  localparam logic [11:0] EDGE_FILL  = FILL;
  localparam logic [11:0] EDGE_EMPTY = EMPTY;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] grid_in = '0;

  logic       hs_f, vs_f, fs_f, act_f;
  logic [3:0] r_f, g_f, b_f;
  logic       hs_s, vs_s, fs_s, act_s;
  logic [3:0] r_s, g_s, b_s;
  logic [11:0] rgb_f, rgb_s;

  int clk_cnt = 0;
  int rel_cnt = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  assign rgb_f = {r_f, g_f, b_f};
  assign rgb_s = {r_s, g_s, b_s};

  grid_vga_renderer dut_full (
    .clk(clk), .reset(reset), .grid_in(grid_in),
    .hSync(hs_f), .vSync(vs_f), .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
    .frame_start(fs_f), .active(act_f)
  );

  grid_vga_renderer #(
    .CELL_PX(CP), .X_OFF(XO), .Y_OFF(YO),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut_small (
    .clk(clk), .reset(reset), .grid_in(grid_in),
    .hSync(hs_s), .vSync(vs_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
    .frame_start(fs_s), .active(act_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return hs_f;
      1:       return act_f;
      2:       return vs_s;
      3:       return fs_s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input logic lvl, output int t);
    int n;
    n = 0;
    while (pick(sel) !== lvl && n < 20000) begin
      @(negedge clk);
      n++;
    end
    t = clk_cnt - rel_cnt;
    if (pick(sel) !== lvl) check({tag, "_timeout"}, {31'd0, pick(sel)}, {31'd0, lvl});
  endtask

  // Output for pixel p of the small screen is registered on the pix_en edge 4*(p+1) after release.
  task automatic goto_px(input int f, input int h, input int v);
    int target;
    target = 4 * (f * FRM + v * HT + h + 1);
    if (clk_cnt - rel_cnt > target) check("schedule", clk_cnt - rel_cnt, target);
    while (clk_cnt - rel_cnt < target) @(negedge clk);
  endtask

  task automatic px(input string tag, input int f, input int h, input int v, input logic [11:0] exp);
    goto_px(f, h, v);
    check(tag, {20'd0, rgb_s}, {20'd0, exp});
  endtask

  initial begin
    int t0, t1, t2;

    repeat (10) @(negedge clk);
    check("rst_hs_full",  hs_f,  1);
    check("rst_vs_full",  vs_f,  1);
    check("rst_rgb_full", rgb_f, 0);
    check("rst_act_full", act_f, 0);
    check("rst_fs_full",  fs_f,  0);
    check("rst_hs_small",  hs_s,  1);
    check("rst_vs_small",  vs_s,  1);
    check("rst_rgb_small", rgb_s, 0);
    check("rst_act_small", act_s, 0);
    check("rst_fs_small",  fs_s,  0);

    grid_in = 256'd1;
    reset   = 1'b1;
    rel_cnt = clk_cnt;

    wait_for("hs_fall", 0, 1'b0, t0);
    check("hs_first_fall", t0, 2628);
    wait_for("hs_rise", 0, 1'b1, t1);
    check("hs_low_width", t1 - t0, 384);
    wait_for("act_rise", 1, 1'b1, t2);
    wait_for("act_fall", 1, 1'b0, t1);
    check("active_width", t1 - t2, 2560);
    wait_for("hs_fall2", 0, 1'b0, t1);
    check("hs_period", t1 - t0, 3200);

    wait_for("fs_rise", 3, 1'b1, t0);
    check("fs_time_f0", t0, 4 * (VV * HT + 1));
    @(negedge clk);
    check("fs_width", fs_s, 0);
    grid_in = '0;
    grid_in[255] = 1'b1;
    grid_in[17]  = 1'b1;

    wait_for("vs_fall", 2, 1'b0, t0);
    check("vs_first_fall", t0, 4 * ((VV + VF) * HT + 1));
    wait_for("vs_rise", 2, 1'b1, t1);
    check("vs_low_width", t1 - t0, 4 * VS * HT);

    // frame 1: only cell (row 0, col 0) from the first snapshot
    px("f1_origin_bg", 1, 0, 0, BG);
    check("f1_origin_active", act_s, 1);
    px("f1_above_pf", 1, 4, 1, BG);
    px("f1_cell00_corner", 1, 3, 2, EDGE_FILL);
    px("f1_left_of_pf", 1, 2, 3, BG);
    px("f1_cell00_in", 1, 4, 3, FILL);
    px("f1_cell10_empty", 1, 7, 3, EMPTY);
    px("f1_right_bg", 1, 51, 3, BG);
    px("f1_hblank_rgb", 1, 52, 3, 12'h000);
    check("f1_hblank_active", act_s, 0);
    goto_px(1, 53, 3);
    check("f1_hs_porch", hs_s, 1);
    goto_px(1, 54, 3);
    check("f1_hs_sync", hs_s, 0);
    px("f1_cell00_last", 1, 5, 4, FILL);
    px("f1_cell01_empty", 1, 4, 6, EMPTY);
    px("f1_cell11_not_yet", 1, 7, 6, EMPTY);

    wait_for("vs_fall2", 2, 1'b0, t1);
    check("vs_period", t1 - t0, 4 * FRM);

    // frame 2: bits 17 and 255; grid_in goes all-ones mid-frame
    px("f2_cell00_cleared", 2, 4, 3, EMPTY);
    px("f2_cell11_corner", 2, 6, 5, EDGE_FILL);
    px("f2_cell11_in", 2, 7, 6, FILL);
    px("f2_cell11_last", 2, 8, 7, FILL);
    goto_px(2, 0, 25);
    grid_in = '1;
    px("f2_coherent", 2, 10, 30, EMPTY);
    px("f2_row14_empty", 2, 49, 46, EMPTY);
    px("f2_col14_empty", 2, 47, 48, EMPTY);
    px("f2_cell_ff_in", 2, 49, 48, FILL);
    px("f2_right_bg", 2, 51, 48, BG);
    px("f2_cell_ff_close", 2, 50, 49, EDGE_FILL);

    wait_for("fs_rise2", 3, 1'b1, t0);
    check("fs_time_f2", t0, 4 * (2 * FRM + VV * HT + 1));

    // frame 3: every cell filled
    px("f3_left_bg", 3, 2, 3, BG);
    px("f3_cell00_corner", 3, 3, 3, EDGE_FILL);
    px("f3_cell00_in", 3, 4, 3, FILL);
    px("f3_cell77_in", 3, 25, 25, FILL);

    goto_px(3, 0, 30);
    reset = 1'b0;
    #1;
    check("mid_rst_hs", hs_s, 1);
    check("mid_rst_vs", vs_s, 1);
    check("mid_rst_rgb", rgb_s, 0);
    check("mid_rst_active", act_s, 0);
    check("mid_rst_fs", fs_s, 0);
    repeat (10) @(negedge clk);
    reset   = 1'b1;
    rel_cnt = clk_cnt;

    // after reset the snapshot is empty even though grid_in is all ones
    px("post_rst_bg", 0, 2, 3, BG);
    px("post_rst_gridline", 0, 3, 3, EDGE_EMPTY);
    px("post_rst_cell00", 0, 4, 3, EMPTY);
    px("post_rst_cell77", 0, 25, 25, EMPTY);
    px("post_rst_cell_ff", 0, 49, 48, EMPTY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
